mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter XLEN, default 32, data and address width.
REQ-002 Parameter CNT_W, default 16, stall-counter width.
REQ-003 clk  in  1  sole clock, rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 a_valid / b_valid  in  1  lane A / lane B bundle slot valid; A is older in program order.
REQ-006 a_op / b_op  in  7  opcode; only LOAD and S_TYPE request memory.
REQ-007 a_funct3 / b_funct3  in  3  access size, passed to memory unchanged.
REQ-008 a_addr, a_wdata / b_addr, b_wdata  in  XLEN  effective address, store data.
REQ-009 flush  in  1  branch/jump flush from EX.
REQ-010 mem_req  out  1  request to the single-ported data memory.
REQ-011 mem_we  out  1  1 for store, 0 for load.
REQ-012 mem_addr, mem_wdata  out  XLEN; mem_funct3  out  3.
REQ-013 mem_ack  in  1  memory completion strobe, variable latency of 1 or more cycles.
REQ-014 mem_rdata  in  XLEN  load data, valid with mem_ack.
REQ-015 a_rdata / b_rdata  out  XLEN  registered load results.
REQ-016 hold  out  1  freeze the upstream pipeline.
REQ-017 done  out  1  one-cycle pulse: the bundle's memory work is complete.
REQ-018 stall_cnt  out  CNT_W  saturating count of cycles with hold=1.

Function
REQ-019 A lane requests memory iff valid=1 and op is LOAD or S_TYPE; any other op is a non-request.
REQ-020 FSM states: IDLE, SERVE_A, SERVE_B, DONE.
REQ-021 IDLE: a bundle with at least one requesting lane is latched (op, funct3, addr, wdata per lane). Next state is SERVE_A if A requests, otherwise SERVE_B.
REQ-022 IDLE with no requesting lane: stay in IDLE, hold=0, done=0.
REQ-023 SERVE_x: mem_req=1 with the latched lane's fields, held stable until the mem_ack cycle.
REQ-024 SERVE_A on mem_ack: go to SERVE_B if B was latched as requesting, else go to DONE.
REQ-025 SERVE_B on mem_ack: go to DONE.
REQ-026 On a load mem_ack, mem_rdata is registered into that lane's rdata on the same edge. A store leaves that lane's rdata unchanged.
REQ-027 DONE: done=1 for exactly one cycle, then IDLE. No new bundle is accepted in DONE.
REQ-028 hold=1 in SERVE_A and SERVE_B, and combinationally in IDLE when a requesting bundle is present. hold=0 in DONE.
REQ-029 Service is strictly A before B, so a store-A/load-B pair to the same address returns the stored value.
REQ-030 mem_req shall never be asserted while no lane is latched.
REQ-031 flush while mem_req=1: the outstanding access completes (it is not cancelled). On its mem_ack, go to IDLE with no done pulse and skip any pending B.
REQ-032 flush in IDLE or DONE: no effect on the FSM.
REQ-033 mem_ack with mem_req=0 is ignored.
REQ-034 stall_cnt increments every cycle hold=1 and saturates at all-ones.

Reset
REQ-035 Reset asserted: state=IDLE; mem_req, mem_we, done=0; hold=0; mem_addr, mem_wdata, mem_funct3, a_rdata, b_rdata, stall_cnt=0; all latched lane fields cleared.
REQ-036 Reset mid-access abandons the access immediately. A later mem_ack for it is ignored under REQ-033.

Structure
REQ-037 The FSM state typedef (arb_state_t) and an is_mem_op(op) helper belong in the shared package, next to the opcode constants LOAD and S_TYPE.
REQ-038 Single module. An optional sub-module mem_lane_latch holds one lane's captured fields and is instantiated twice.

Verification
REQ-039 A=LOAD 0x100, B=R_TYPE, ack after 2 cycles, rdata=0xDEADBEEF -> one mem_req (we=0); a_rdata=0xDEADBEEF; done pulses once; hold high 3 cycles.
REQ-040 A=S_TYPE 0x40 wdata=0x55, B=LOAD 0x40, memory model -> two requests, A first; b_rdata=0x55.
REQ-041 A=R_TYPE, B=LOAD 0x8 -> single request with B fields; a_rdata unchanged.
REQ-042 A=LOAD, B=LOAD, flush during A wait -> A completes, no B request, no done, return to IDLE.
REQ-043 rst_n low during SERVE_B, then stray mem_ack -> outputs at reset values; ack ignored; IDLE.
REQ-044 CNT_W=4, 20 stalled cycles -> stall_cnt saturates at 15.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared opcode constants, FSM state type and request helper
// for the two-lane data-memory arbiter.
package mem_arbiter_pkg;

    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] S_TYPE = 7'b0100011;
    localparam logic [6:0] R_TYPE = 7'b0110011;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_A = 2'd1,
        SERVE_B = 2'd2,
        DONE    = 2'd3
    } arb_state_t;

    function automatic logic is_mem_op(input logic [6:0] op);
        return (op == LOAD) || (op == S_TYPE);
    endfunction

endpackage

// File: rtl/mem_lane_latch.sv
// Captures one lane's memory request fields while a bundle is served.
// Ports: clk, rst_n, load/clear strobes, lane inputs in, latched fields out.
module mem_lane_latch
    import mem_arbiter_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic            clear,
    input  logic            req_in,
    input  logic [6:0]      op_in,
    input  logic [2:0]      funct3_in,
    input  logic [XLEN-1:0] addr_in,
    input  logic [XLEN-1:0] wdata_in,
    output logic            req_q,
    output logic [6:0]      op_q,
    output logic [2:0]      funct3_q,
    output logic [XLEN-1:0] addr_q,
    output logic [XLEN-1:0] wdata_q
);

    logic            req_d;
    logic [6:0]      op_d;
    logic [2:0]      funct3_d;
    logic [XLEN-1:0] addr_d;
    logic [XLEN-1:0] wdata_d;

    always_comb begin
        req_d    = req_q;
        op_d     = op_q;
        funct3_d = funct3_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        if (clear) begin
            req_d    = 1'b0;
            op_d     = '0;
            funct3_d = '0;
            addr_d   = '0;
            wdata_d  = '0;
        end else if (load) begin
            req_d    = req_in;
            op_d     = op_in;
            funct3_d = funct3_in;
            addr_d   = addr_in;
            wdata_d  = wdata_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q    <= 1'b0;
            op_q     <= '0;
            funct3_q <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            req_q    <= req_d;
            op_q     <= op_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises a dual-issue bundle's loads/stores onto one data-memory
// port, lane A first, freezing the pipeline with hold while it works.
// Ports: lane A/B bundle in, flush, memory req/ack bus, per-lane load
// results, hold, done pulse and a saturating stall counter.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a_valid,
    input  logic [6:0]       a_op,
    input  logic [2:0]       a_funct3,
    input  logic [XLEN-1:0]  a_addr,
    input  logic [XLEN-1:0]  a_wdata,
    input  logic             b_valid,
    input  logic [6:0]       b_op,
    input  logic [2:0]       b_funct3,
    input  logic [XLEN-1:0]  b_addr,
    input  logic [XLEN-1:0]  b_wdata,
    input  logic             flush,
    output logic             mem_req,
    output logic             mem_we,
    output logic [XLEN-1:0]  mem_addr,
    output logic [XLEN-1:0]  mem_wdata,
    output logic [2:0]       mem_funct3,
    input  logic             mem_ack,
    input  logic [XLEN-1:0]  mem_rdata,
    output logic [XLEN-1:0]  a_rdata,
    output logic [XLEN-1:0]  b_rdata,
    output logic             hold,
    output logic             done,
    output logic [CNT_W-1:0] stall_cnt
);

    arb_state_t state_q, state_d;

    logic             flush_pend_q, flush_pend_d;
    logic [XLEN-1:0]  a_rdata_q, a_rdata_d;
    logic [XLEN-1:0]  b_rdata_q, b_rdata_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic a_req, b_req, any_req;
    logic lat_load, lat_clear;
    logic sel_b, abort;

    logic            la_req, lb_req;
    logic [6:0]      la_op, lb_op;
    logic [2:0]      la_funct3, lb_funct3;
    logic [XLEN-1:0] la_addr, lb_addr;
    logic [XLEN-1:0] la_wdata, lb_wdata;

    assign a_req   = a_valid && is_mem_op(a_op);
    assign b_req   = b_valid && is_mem_op(b_op);
    assign any_req = a_req || b_req;

    assign lat_load  = (state_q == IDLE) && any_req;
    assign lat_clear = (state_q != IDLE) && (state_d == IDLE);

    mem_lane_latch #(.XLEN(XLEN)) u_lane_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (lat_load),
        .clear     (lat_clear),
        .req_in    (a_req),
        .op_in     (a_op),
        .funct3_in (a_funct3),
        .addr_in   (a_addr),
        .wdata_in  (a_wdata),
        .req_q     (la_req),
        .op_q      (la_op),
        .funct3_q  (la_funct3),
        .addr_q    (la_addr),
        .wdata_q   (la_wdata)
    );

    mem_lane_latch #(.XLEN(XLEN)) u_lane_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (lat_load),
        .clear     (lat_clear),
        .req_in    (b_req),
        .op_in     (b_op),
        .funct3_in (b_funct3),
        .addr_in   (b_addr),
        .wdata_in  (b_wdata),
        .req_q     (lb_req),
        .op_q      (lb_op),
        .funct3_q  (lb_funct3),
        .addr_q    (lb_addr),
        .wdata_q   (lb_wdata)
    );

    // A flush seen at any point of the wait aborts the bundle on the ack,
    // even if flush has dropped by then.
    assign abort = flush || flush_pend_q;

    always_comb begin
        state_d      = state_q;
        flush_pend_d = flush_pend_q;
        a_rdata_d    = a_rdata_q;
        b_rdata_d    = b_rdata_q;
        hold         = 1'b0;
        done         = 1'b0;
        mem_req      = 1'b0;
        sel_b        = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    hold    = 1'b1;
                    state_d = a_req ? SERVE_A : SERVE_B;
                end
            end
            SERVE_A: begin
                hold    = 1'b1;
                mem_req = la_req;
                if (mem_ack && mem_req) begin
                    if (la_op != S_TYPE) begin
                        a_rdata_d = mem_rdata;
                    end
                    if (abort) begin
                        state_d = IDLE;
                    end else if (lb_req) begin
                        state_d = SERVE_B;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            SERVE_B: begin
                hold    = 1'b1;
                sel_b   = 1'b1;
                mem_req = lb_req;
                if (mem_ack && mem_req) begin
                    if (lb_op != S_TYPE) begin
                        b_rdata_d = mem_rdata;
                    end
                    state_d = abort ? IDLE : DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (mem_req && mem_ack) begin
            flush_pend_d = 1'b0;
        end else if (mem_req && flush) begin
            flush_pend_d = 1'b1;
        end
    end

    // Bus fields are forced to zero whenever no access is in flight.
    always_comb begin
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        mem_funct3 = '0;
        if (mem_req) begin
            if (sel_b) begin
                mem_we     = (lb_op == S_TYPE);
                mem_addr   = lb_addr;
                mem_wdata  = lb_wdata;
                mem_funct3 = lb_funct3;
            end else begin
                mem_we     = (la_op == S_TYPE);
                mem_addr   = la_addr;
                mem_wdata  = la_wdata;
                mem_funct3 = la_funct3;
            end
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (hold && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            flush_pend_q <= 1'b0;
            a_rdata_q    <= '0;
            b_rdata_q    <= '0;
            stall_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            flush_pend_q <= flush_pend_d;
            a_rdata_q    <= a_rdata_d;
            b_rdata_q    <= b_rdata_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign a_rdata   = a_rdata_q;
    assign b_rdata   = b_rdata_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: vector table plus reset and saturation
// sequences, with a request scoreboard and a small memory model.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        a_valid, b_valid;
    logic [6:0]  a_op, b_op;
    logic [2:0]  a_funct3, b_funct3;
    logic [31:0] a_addr, a_wdata, b_addr, b_wdata;
    logic        flush;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    logic        mem_req, mem_we, hold, done;
    logic [31:0] mem_addr, mem_wdata, a_rdata, b_rdata;
    logic [2:0]  mem_funct3;
    logic [15:0] stall_cnt;

    logic        s_mem_req, s_mem_we, s_hold, s_done;
    logic [31:0] s_mem_addr, s_mem_wdata, s_a_rdata, s_b_rdata;
    logic [2:0]  s_mem_funct3;
    logic [3:0]  s_stall_cnt;

    mem_arbiter #(.XLEN(32), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_op(a_op), .a_funct3(a_funct3),
        .a_addr(a_addr), .a_wdata(a_wdata),
        .b_valid(b_valid), .b_op(b_op), .b_funct3(b_funct3),
        .b_addr(b_addr), .b_wdata(b_wdata),
        .flush(flush),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_funct3(mem_funct3),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .a_rdata(a_rdata), .b_rdata(b_rdata),
        .hold(hold), .done(done), .stall_cnt(stall_cnt)
    );

    mem_arbiter #(.XLEN(32), .CNT_W(4)) u_sat (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_op(a_op), .a_funct3(a_funct3),
        .a_addr(a_addr), .a_wdata(a_wdata),
        .b_valid(b_valid), .b_op(b_op), .b_funct3(b_funct3),
        .b_addr(b_addr), .b_wdata(b_wdata),
        .flush(flush),
        .mem_req(s_mem_req), .mem_we(s_mem_we), .mem_addr(s_mem_addr),
        .mem_wdata(s_mem_wdata), .mem_funct3(s_mem_funct3),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .a_rdata(s_a_rdata), .b_rdata(s_b_rdata),
        .hold(s_hold), .done(s_done), .stall_cnt(s_stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    typedef struct {
        logic        a_valid;
        logic [6:0]  a_op;
        logic [31:0] a_addr;
        logic [31:0] a_wdata;
        logic        b_valid;
        logic [6:0]  b_op;
        logic [31:0] b_addr;
        logic [31:0] b_wdata;
        int          lat;
        int          flush_cyc;
        int          exp_nreq;
        int          exp_done;
        int          exp_hold;
        logic [31:0] exp_a;
        logic [31:0] exp_b;
    } vec_t;

    localparam logic [2:0] A_F3 = 3'b010;
    localparam logic [2:0] B_F3 = 3'b100;

    int   checks = 0;
    int   errors = 0;
    int   hold_total = 0;
    int   done_seen = 0;
    int   req_seen = 0;
    int   age = 0;
    int   lat = 1;
    logic cur_ok = 1'b0;
    req_t cur;
    req_t exp_q[$];
    logic [31:0] mem_model [0:255];
    vec_t vecs [9];

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_cnt(input string name);
        int sat;
        sat = (hold_total > 15) ? 15 : hold_total;
        check({name, "_stall"}, 64'(stall_cnt), 64'(hold_total));
        check({name, "_stall_sat"}, 64'(s_stall_cnt), 64'(sat));
    endtask

    // One clock: drive, sample away from the edge, score and answer memory.
    task automatic step(input logic va, input logic vb, input logic fl);
        req_t r;
        @(negedge clk);
        mem_ack = 1'b0;
        a_valid = va;
        b_valid = vb;
        flush   = fl;
        #1;
        if (hold) hold_total++;
        if (done) done_seen++;
        if (mem_req) begin
            if (age == 0) begin
                req_seen++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    cur_ok = 1'b0;
                    $display("FAIL req_unexpected: addr %0h we %0b",
                             mem_addr, mem_we);
                end else begin
                    cur    = exp_q.pop_front();
                    cur_ok = 1'b1;
                end
            end
            if (cur_ok) begin
                r.we    = mem_we;
                r.f3    = mem_funct3;
                r.addr  = mem_addr;
                r.wdata = mem_wdata;
                check("req_we", 64'(r.we), 64'(cur.we));
                check("req_f3", 64'(r.f3), 64'(cur.f3));
                check("req_addr", 64'(r.addr), 64'(cur.addr));
                check("req_wdata", 64'(r.wdata), 64'(cur.wdata));
            end
            age++;
            if (age >= lat) begin
                mem_ack = 1'b1;
                if (mem_we) begin
                    mem_model[mem_addr[9:2]] = mem_wdata;
                    mem_rdata = 32'hBAD0_0000;
                end else begin
                    mem_rdata = mem_model[mem_addr[9:2]];
                end
                age = 0;
            end
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        logic a_rq, b_rq;
        req_t r;
        int   h0;
        a_op    = v.a_op;
        a_addr  = v.a_addr;
        a_wdata = v.a_wdata;
        b_op    = v.b_op;
        b_addr  = v.b_addr;
        b_wdata = v.b_wdata;
        lat     = v.lat;
        a_rq = v.a_valid && (v.a_op == LOAD || v.a_op == S_TYPE);
        b_rq = v.b_valid && (v.b_op == LOAD || v.b_op == S_TYPE);
        if (a_rq) begin
            r.we = (v.a_op == S_TYPE); r.f3 = A_F3;
            r.addr = v.a_addr; r.wdata = v.a_wdata;
            exp_q.push_back(r);
        end
        if (b_rq && !(a_rq && v.flush_cyc >= 1)) begin
            r.we = (v.b_op == S_TYPE); r.f3 = B_F3;
            r.addr = v.b_addr; r.wdata = v.b_wdata;
            exp_q.push_back(r);
        end
        done_seen = 0;
        req_seen  = 0;
        h0        = hold_total;
        for (int c = 0; c < 15; c++) begin
            step(c == 0 ? v.a_valid : 1'b0,
                 c == 0 ? v.b_valid : 1'b0,
                 c == v.flush_cyc);
        end
        check($sformatf("v%0d_nreq", idx), 64'(req_seen), 64'(v.exp_nreq));
        check($sformatf("v%0d_qleft", idx), 64'(exp_q.size()), 64'd0);
        check($sformatf("v%0d_done", idx), 64'(done_seen), 64'(v.exp_done));
        check($sformatf("v%0d_hold", idx), 64'(hold_total - h0),
              64'(v.exp_hold));
        check($sformatf("v%0d_a_rdata", idx), 64'(a_rdata), 64'(v.exp_a));
        check($sformatf("v%0d_b_rdata", idx), 64'(b_rdata), 64'(v.exp_b));
        check_cnt($sformatf("v%0d", idx));
        exp_q.delete();
    endtask

    initial begin
        req_t r;
        for (int i = 0; i < 256; i++) begin
            mem_model[i] = 32'h1000_0000 + 32'(i * 4);
        end
        mem_model[64] = 32'hDEAD_BEEF;

        vecs[0] = '{1'b1, LOAD, 32'h100, 32'h0, 1'b1, R_TYPE, 32'h0, 32'h0,
                    2, -1, 1, 1, 3, 32'hDEAD_BEEF, 32'h0};
        vecs[1] = '{1'b1, S_TYPE, 32'h40, 32'h55, 1'b1, LOAD, 32'h40, 32'h0,
                    1, -1, 2, 1, 3, 32'hDEAD_BEEF, 32'h55};
        vecs[2] = '{1'b1, R_TYPE, 32'h0, 32'h0, 1'b1, LOAD, 32'h8, 32'h0,
                    3, -1, 1, 1, 4, 32'hDEAD_BEEF, 32'h1000_0008};
        vecs[3] = '{1'b1, LOAD, 32'h10, 32'h0, 1'b1, LOAD, 32'h20, 32'h0,
                    3, 2, 1, 0, 4, 32'h1000_0010, 32'h1000_0008};
        vecs[4] = '{1'b1, R_TYPE, 32'h0, 32'h0, 1'b0, LOAD, 32'h20, 32'h0,
                    1, -1, 0, 0, 0, 32'h1000_0010, 32'h1000_0008};
        vecs[5] = '{1'b0, LOAD, 32'h30, 32'h0, 1'b1, S_TYPE, 32'h80, 32'h1234,
                    2, -1, 1, 1, 3, 32'h1000_0010, 32'h1000_0008};
        vecs[6] = '{1'b1, LOAD, 32'h80, 32'h0, 1'b1, LOAD, 32'h100, 32'h0,
                    2, -1, 2, 1, 5, 32'h1234, 32'hDEAD_BEEF};
        vecs[7] = '{1'b1, LOAD, 32'h40, 32'h0, 1'b0, LOAD, 32'h0, 32'h0,
                    1, 0, 1, 1, 2, 32'h55, 32'hDEAD_BEEF};
        vecs[8] = '{1'b1, LOAD, 32'h8, 32'h0, 1'b0, LOAD, 32'h0, 32'h0,
                    1, 2, 1, 1, 2, 32'h1000_0008, 32'hDEAD_BEEF};

        rst_n = 1'b0;
        a_valid = 1'b0; b_valid = 1'b0;
        a_op = '0; b_op = '0;
        a_funct3 = A_F3; b_funct3 = B_F3;
        a_addr = '0; a_wdata = '0; b_addr = '0; b_wdata = '0;
        flush = 1'b0; mem_ack = 1'b0; mem_rdata = '0;

        repeat (2) @(negedge clk);
        #1;
        check("rst_mem_req", 64'(mem_req), 64'd0);
        check("rst_hold", 64'(hold), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_mem_addr", 64'(mem_addr), 64'd0);
        check("rst_a_rdata", 64'(a_rdata), 64'd0);
        check("rst_b_rdata", 64'(b_rdata), 64'd0);
        check_cnt("rst");
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            run_vec(i, vecs[i]);
        end

        // Reset while lane B waits, then a stray ack.
        exp_q.delete();
        age = 0; lat = 1;
        a_op = LOAD; a_addr = 32'h10; a_wdata = '0;
        b_op = LOAD; b_addr = 32'h20; b_wdata = '0;
        r.we = 1'b0; r.f3 = A_F3; r.addr = 32'h10; r.wdata = '0;
        exp_q.push_back(r);
        r.f3 = B_F3; r.addr = 32'h20;
        exp_q.push_back(r);
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        lat = 10;
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        check("rb_serve_b_req", 64'(mem_req), 64'd1);
        check("rb_serve_b_addr", 64'(mem_addr), 64'h20);
        check("rb_a_loaded", 64'(a_rdata), 64'h1000_0010);
        rst_n = 1'b0;
        #1;
        hold_total = 0;
        check("rb_mem_req", 64'(mem_req), 64'd0);
        check("rb_mem_addr", 64'(mem_addr), 64'd0);
        check("rb_hold", 64'(hold), 64'd0);
        check("rb_done", 64'(done), 64'd0);
        check("rb_a_rdata", 64'(a_rdata), 64'd0);
        check("rb_b_rdata", 64'(b_rdata), 64'd0);
        check_cnt("rb");
        @(negedge clk);
        rst_n = 1'b1;
        age = 0;
        exp_q.delete();
        mem_ack = 1'b1;
        mem_rdata = 32'hFFFF_FFFF;
        #1;
        check("stray_done", 64'(done), 64'd0);
        @(negedge clk);
        mem_ack = 1'b0;
        #1;
        check("stray_a_rdata", 64'(a_rdata), 64'd0);
        check("stray_b_rdata", 64'(b_rdata), 64'd0);
        check("stray_mem_req", 64'(mem_req), 64'd0);
        check("stray_done2", 64'(done), 64'd0);
        check_cnt("stray");

        // Long wait to drive the 4-bit counter into saturation.
        lat = 20;
        a_op = LOAD; a_addr = 32'h40;
        r.we = 1'b0; r.f3 = A_F3; r.addr = 32'h40; r.wdata = '0;
        exp_q.push_back(r);
        done_seen = 0;
        req_seen  = 0;
        step(1'b1, 1'b0, 1'b0);
        for (int c = 0; c < 24; c++) begin
            step(1'b0, 1'b0, 1'b0);
        end
        check("sat_nreq", 64'(req_seen), 64'd1);
        check("sat_done", 64'(done_seen), 64'd1);
        check("sat_hold", 64'(hold_total), 64'd21);
        check("sat_a_rdata", 64'(a_rdata), 64'h55);
        check("sat_cnt4", 64'(s_stall_cnt), 64'd15);
        check_cnt("sat");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
